// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite definitions for the SRAM subordinate.
//   htrans_t        : transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   HSIZE_*         : supported transfer sizes
//   HRESP_*         : response encodings
//   slv_state_t     : subordinate response FSM states
//   xfer_legal()    : size/alignment/range legality of an address phase
//   byte_en()       : byte-lane enables for a legal transfer
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } slv_state_t;

    // Size must be byte/half/word, naturally aligned, and inside the array.
    function automatic logic xfer_legal(input logic [31:0] addr,
                                        input logic [2:0]  size,
                                        input logic [29:0] depth_words);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr[0];
            HSIZE_WORD: ok = (addr[1:0] == 2'b00);
            default:    ok = 1'b0;
        endcase
        if (addr[31:2] >= depth_words) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

    // Lanes follow little-endian byte addressing within the 32-bit word.
    function automatic logic [3:0] byte_en(input logic [2:0] size,
                                           input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lo;
            HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite signal bundle between a manager and this
// subordinate. HREADY is the bus-level ready returned by the interconnect.
//   master modport : drives address/control/write data, HREADY
//   slave modport  : drives HRDATA, HREADYOUT, HRESP
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_slv_mem.sv
// ahb_slv_mem: DEPTH x 32-bit storage with one byte-enabled synchronous
// write port and one asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write strobe, be selects the byte lanes of wdata to store
//   waddr : word address for writes
//   raddr : word address for the combinational read, rdata the word
module ahb_slv_mem #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [3:0]               be,
    input  logic [31:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);
    logic [31:0] mem_r [DEPTH];

    // Byte-lane write port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[raddr];
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite subordinate in front of a byte-enabled SRAM.
//   HCLK   : bus clock, rising edge
//   HRESET : asynchronous active-low reset
//   bus    : AHB-Lite signals (slave modport)
// Parameters: DEPTH (words, power of two), WAIT_STATES (0-7).
// Build option: define AHB_SLV_WAITSTATE_EN to insert WAIT_STATES wait
// cycles in every legal transfer; otherwise all legal transfers are
// zero-wait and WAIT_STATES has no effect. Illegal accesses always get a
// two-cycle ERROR response.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic             HCLK,
    input  logic             HRESET,
    ahb_sram_slave_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    slv_state_t  state_r;
    logic        hreadyout_r;
    logic        hresp_r;
    logic [31:0] hrdata_r;
    logic        pending_r;
    logic        write_r;
    logic [3:0]  be_r;
    logic [AW-1:0] addr_r;

    logic          accept_s;
    logic          legal_s;
    logic          ready_cyc_s;
    logic          commit_s;
    logic          last_wait_s;
    logic          load_rd_s;
    logic [AW-1:0] rd_addr_s;
    logic [31:0]   mem_rdata_s;
    logic [31:0]   fwd_rdata_s;
    logic          unused_s;

`ifdef AHB_SLV_WAITSTATE_EN
    localparam logic       ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);
    logic [2:0] wait_cnt_r;
    assign last_wait_s = (state_r == ST_WAIT) && (wait_cnt_r <= 3'd1);
    assign unused_s    = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0]};
`else
    localparam logic ZERO_WAIT = 1'b1;
    assign last_wait_s = 1'b0;
    assign unused_s    = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0], 3'(WAIT_STATES)};
`endif

    assign accept_s    = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign legal_s     = xfer_legal(bus.HADDR, bus.HSIZE, 30'(DEPTH));
    // IDLE and ERR2 are the cycles in which a new address phase can land.
    assign ready_cyc_s = (state_r == ST_IDLE) || (state_r == ST_ERR2);
    // A legal write commits on the edge that closes its data phase.
    assign commit_s    = pending_r & write_r & ready_cyc_s;

    // Zero-wait reads sample the incoming address; waited reads the held one.
    assign rd_addr_s = ready_cyc_s ? bus.HADDR[AW+1:2] : addr_r;
    assign load_rd_s = ready_cyc_s ? (accept_s & legal_s & ~bus.HWRITE & ZERO_WAIT)
                                   : (last_wait_s & ~write_r);

    // A write finishing on the same edge as a back-to-back read of the same
    // word is forwarded lane by lane so the read sees the new data.
    always_comb begin
        fwd_rdata_s = mem_rdata_s;
        for (int i = 0; i < 4; i++) begin
            fwd_rdata_s[8*i +: 8] = (commit_s && (addr_r == rd_addr_s) && be_r[i])
                                    ? bus.HWDATA[8*i +: 8] : mem_rdata_s[8*i +: 8];
        end
    end

    ahb_slv_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (HCLK),
        .we    (commit_s),
        .waddr (addr_r),
        .be    (be_r),
        .wdata (bus.HWDATA),
        .raddr (rd_addr_s),
        .rdata (mem_rdata_s)
    );

    // Response FSM with registered HREADYOUT/HRESP/HRDATA and data-phase state.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_r     <= ST_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
            hrdata_r    <= 32'd0;
            pending_r   <= 1'b0;
            write_r     <= 1'b0;
            be_r        <= 4'b0000;
            addr_r      <= '0;
`ifdef AHB_SLV_WAITSTATE_EN
            wait_cnt_r  <= 3'd0;
`endif
        end else begin
            hrdata_r <= load_rd_s ? fwd_rdata_s : 32'd0;
            case (state_r)
                ST_IDLE, ST_ERR2: begin
                    if (accept_s && legal_s) begin
                        pending_r <= 1'b1;
                        write_r   <= bus.HWRITE;
                        be_r      <= byte_en(bus.HSIZE, bus.HADDR[1:0]);
                        addr_r    <= bus.HADDR[AW+1:2];
                        hresp_r   <= HRESP_OKAY;
`ifdef AHB_SLV_WAITSTATE_EN
                        if (ZERO_WAIT) begin
                            state_r     <= ST_IDLE;
                            hreadyout_r <= 1'b1;
                        end else begin
                            state_r     <= ST_WAIT;
                            hreadyout_r <= 1'b0;
                            wait_cnt_r  <= WAIT_LOAD;
                        end
`else
                        state_r     <= ST_IDLE;
                        hreadyout_r <= 1'b1;
`endif
                    end else if (accept_s) begin
                        pending_r   <= 1'b0;
                        state_r     <= ST_ERR1;
                        hreadyout_r <= 1'b0;
                        hresp_r     <= HRESP_ERROR;
                    end else begin
                        pending_r   <= 1'b0;
                        state_r     <= ST_IDLE;
                        hreadyout_r <= 1'b1;
                        hresp_r     <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
`ifdef AHB_SLV_WAITSTATE_EN
                    if (last_wait_s) begin
                        state_r     <= ST_IDLE;
                        hreadyout_r <= 1'b1;
                        wait_cnt_r  <= 3'd0;
                    end else begin
                        state_r     <= ST_WAIT;
                        hreadyout_r <= 1'b0;
                        wait_cnt_r  <= wait_cnt_r - 3'd1;
                    end
`else
                    state_r     <= ST_IDLE;
                    hreadyout_r <= 1'b1;
`endif
                    hresp_r <= HRESP_OKAY;
                end
                ST_ERR1: begin
                    state_r     <= ST_ERR2;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= HRESP_ERROR;
                    pending_r   <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    hreadyout_r <= 1'b1;
                    hresp_r     <= HRESP_OKAY;
                    pending_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HREADYOUT = hreadyout_r;
    assign bus.HRESP     = hresp_r;
    assign bus.HRDATA    = hrdata_r;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: randomized scoreboard bench for ahb_sram_slave.
// The driver issues address phases and pushes the expected data-phase
// response computed from a byte-level memory model; the monitor watches the
// bus and pops/compares when each data phase runs.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int DEPTH_T = 256;
    localparam int WAIT_T  = 2;
`ifdef AHB_SLV_WAITSTATE_EN
    localparam int W_EXP = WAIT_T;
`else
    localparam int W_EXP = 0;
`endif

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] data;
    } sb_t;

    logic HCLK = 1'b0;
    logic HRESET;
    ahb_sram_slave_if bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahb_sram_slave #(.DEPTH(DEPTH_T), .WAIT_STATES(WAIT_T)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    int          n_vec = 0;
    int          n_err = 0;
    sb_t         sbq[$];
    logic [31:0] mem_m [DEPTH_T];
    logic [2:0]  burst_v = 3'b000;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endfunction

    function automatic bit m_legal(input logic [31:0] addr, input logic [2:0] sz);
        if (sz > 3'd2) return 1'b0;
        if ((addr % (32'd1 << sz)) != 32'd0) return 1'b0;
        if (addr >= 32'(DEPTH_T * 4)) return 1'b0;
        return 1'b1;
    endfunction

    // Each addressed byte takes the HWDATA lane matching its address.
    function automatic void m_write(input logic [31:0] addr, input logic [2:0] sz, input logic [31:0] wd);
        for (int k = 0; k < (1 << sz); k++) begin
            int unsigned b;
            int unsigned ln;
            b  = addr + k;
            ln = b % 4;
            mem_m[b / 4][8*ln +: 8] = wd[8*ln +: 8];
        end
    endfunction

    // Present one address phase, wait for it to be taken, then supply data.
    task automatic do_xfer(input bit sel, input logic [1:0] trans, input bit wr,
                           input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        int  n;
        sb_t e;
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HWRITE = wr;
        bus.HSIZE  = sz;
        bus.HADDR  = addr;
        bus.HBURST = burst_v;
        bus.HPROT  = 4'h3;
        n = 0;
        @(negedge HCLK);
        while (!bus.HREADYOUT && n < 20) begin
            n++;
            @(negedge HCLK);
        end
        if (n >= 20) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got HREADYOUT=0 for 20 cycles, expected 1");
        end
        @(posedge HCLK);
        #1;
        if (sel && trans[1]) begin
            e.err  = !m_legal(addr, sz);
            e.rd   = !wr && !e.err;
            e.data = e.rd ? mem_m[addr >> 2] : 32'd0;
            if (!e.err && wr) m_write(addr, sz, wd);
            sbq.push_back(e);
        end
        bus.HWDATA = wr ? wd : $urandom;
    endtask

    task automatic idle_cycle();
        do_xfer(1'b0, IDLE, 1'b0, HSIZE_WORD, 32'd0, 32'd0);
    endtask

    // Monitor: pops an expectation when a data phase starts and checks it.
    initial begin
        bit  start;
        bit  inph;
        int  cyc;
        sb_t cur;
        start = 1'b0;
        inph  = 1'b0;
        cyc   = 0;
        forever begin
            @(negedge HCLK);
            if (!HRESET) begin
                start = 1'b0;
                inph  = 1'b0;
            end else begin
                if (start) begin
                    start = 1'b0;
                    if (sbq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_empty: got data phase, expected queued entry");
                    end else begin
                        cur  = sbq.pop_front();
                        inph = 1'b1;
                        cyc  = 0;
                    end
                end
                if (inph) begin
                    cyc++;
                    if (cur.err) begin
                        if (cyc == 1) begin
                            chk("err1_hreadyout", 32'(bus.HREADYOUT), 32'd0);
                            chk("err1_hresp", 32'(bus.HRESP), 32'd1);
                        end else begin
                            chk("err2_hreadyout", 32'(bus.HREADYOUT), 32'd1);
                            chk("err2_hresp", 32'(bus.HRESP), 32'd1);
                            inph = 1'b0;
                        end
                    end else if (!bus.HREADYOUT) begin
                        chk("wait_hresp", 32'(bus.HRESP), 32'd0);
                        if (cyc > W_EXP) begin
                            chk("wait_count", 32'(cyc), 32'(W_EXP));
                            inph = 1'b0;
                        end
                    end else begin
                        chk("ok_waits", 32'(cyc - 1), 32'(W_EXP));
                        chk("ok_hresp", 32'(bus.HRESP), 32'd0);
                        chk(cur.rd ? "read_data" : "write_hrdata", bus.HRDATA, cur.data);
                        inph = 1'b0;
                    end
                end else begin
                    chk("idle_hreadyout", 32'(bus.HREADYOUT), 32'd1);
                    chk("idle_hresp", 32'(bus.HRESP), 32'd0);
                    chk("idle_hrdata", bus.HRDATA, 32'd0);
                end
                if (bus.HSEL && bus.HREADYOUT && bus.HTRANS[1]) start = 1'b1;
            end
        end
    end

    // Stimulus.
    initial begin
        int t;
        HRESET     = 1'b0;
        bus.HSEL   = 1'b0;
        bus.HTRANS = IDLE;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = HSIZE_WORD;
        bus.HADDR  = 32'd0;
        bus.HBURST = 3'b000;
        bus.HPROT  = 4'h3;
        bus.HWDATA = 32'd0;
        repeat (3) @(negedge HCLK);
        #1;
        chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("rst_hresp", 32'(bus.HRESP), 32'd0);
        chk("rst_hrdata", bus.HRDATA, 32'd0);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;

        // Give words 0..15 known contents.
        for (int w = 0; w < 16; w++) begin
            do_xfer(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'(w * 4), $urandom);
        end
        do_xfer(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h1234_5678);
        idle_cycle();
        idle_cycle();

        // Reset inside the data phase of a write to 0x10: nothing committed.
        bus.HSEL   = 1'b1;
        bus.HTRANS = NONSEQ;
        bus.HWRITE = 1'b1;
        bus.HSIZE  = HSIZE_WORD;
        bus.HADDR  = 32'h10;
        @(negedge HCLK);
        @(posedge HCLK);
        #1;
        bus.HWDATA = 32'hCAFE_F00D;
        bus.HSEL   = 1'b0;
        bus.HTRANS = IDLE;
        #1;
        HRESET = 1'b0;
        #1;
        chk("midrst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("midrst_hresp", 32'(bus.HRESP), 32'd0);
        chk("midrst_hrdata", bus.HRDATA, 32'd0);
        @(negedge HCLK);
        @(negedge HCLK);
        #1;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        do_xfer(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'd0);

        // Back-to-back write then read of the same word.
        do_xfer(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'h04, 32'hDEAD_BEEF);
        do_xfer(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h04, 32'd0);

        // Byte merge into an existing word.
        do_xfer(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'h08, 32'h1122_3344);
        do_xfer(1'b1, NONSEQ, 1'b1, HSIZE_BYTE, 32'h09, 32'h0000_AA00);
        do_xfer(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h08, 32'd0);

        // Misaligned word write, then a transfer taken in ERR2, then read-back.
        do_xfer(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'h02, 32'h5555_5555);
        do_xfer(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h00, 32'd0);
        do_xfer(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'(DEPTH_T * 4), 32'h6666_6666);
        do_xfer(1'b1, NONSEQ, 1'b0, HSIZE_HALF, 32'h05, 32'd0);
        idle_cycle();

        // INCR4 read burst.
        burst_v = 3'b011;
        do_xfer(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h00, 32'd0);
        do_xfer(1'b1, SEQ,    1'b0, HSIZE_WORD, 32'h04, 32'd0);
        do_xfer(1'b1, SEQ,    1'b0, HSIZE_WORD, 32'h08, 32'd0);
        do_xfer(1'b1, SEQ,    1'b0, HSIZE_WORD, 32'h0C, 32'd0);

        // BUSY between beats, then IDLE while still selected.
        burst_v = 3'b001;
        do_xfer(1'b1, NONSEQ, 1'b1, HSIZE_WORD, 32'h20, 32'h0BAD_CAFE);
        do_xfer(1'b1, BUSY,   1'b1, HSIZE_WORD, 32'h24, 32'hFFFF_FFFF);
        do_xfer(1'b1, SEQ,    1'b1, HSIZE_WORD, 32'h24, 32'h7777_8888);
        do_xfer(1'b1, IDLE,   1'b1, HSIZE_WORD, 32'h28, 32'hFFFF_FFFF);
        do_xfer(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h20, 32'd0);
        do_xfer(1'b1, NONSEQ, 1'b0, HSIZE_WORD, 32'h24, 32'd0);
        burst_v = 3'b000;

        // Random traffic over words 0..15 plus some out-of-range addresses.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [1:0]  tr;
            if ($urandom_range(0, 9) == 0) a = 32'(DEPTH_T * 4) + 32'($urandom_range(0, 63));
            else                            a = 32'($urandom_range(0, 63));
            tr = 2'($urandom_range(0, 3));
            do_xfer($urandom_range(0, 7) != 0, tr, 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 3)), a, $urandom);
        end

        idle_cycle();
        t = 0;
        while (sbq.size() != 0 && t < 50) begin
            t++;
            @(negedge HCLK);
        end
        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending entries, expected 0", sbq.size());
        end
        repeat (W_EXP + 4) @(negedge HCLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
